// File: rtl/fifo_stream_drain_if.sv
// Drain-side bundle: sync_fifo read port plus the framed valid/ready output stream.
// pkt_count exists only when FIFO_STREAM_DRAIN_PKTCNT_EN is defined.
interface fifo_stream_drain_if #(
   parameter int DATA_WIDTH = 32
);
   logic [DATA_WIDTH-1:0] fifo_dout;
   logic                  fifo_empty;
   logic                  fifo_read_en;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_valid;
   logic                  out_ready;
   logic                  out_last;
`ifdef FIFO_STREAM_DRAIN_PKTCNT_EN
   logic [15:0]           pkt_count;
`endif

   modport master (
      input  fifo_dout, fifo_empty, out_ready,
      output fifo_read_en, out_data, out_valid, out_last
`ifdef FIFO_STREAM_DRAIN_PKTCNT_EN
      , output pkt_count
`endif
   );

   modport slave (
      output fifo_dout, fifo_empty, out_ready,
      input  fifo_read_en, out_data, out_valid, out_last
`ifdef FIFO_STREAM_DRAIN_PKTCNT_EN
      , input pkt_count
`endif
   );
endinterface

// File: rtl/fifo_stream_drain.sv
// Pops sync_fifo words into a 2-entry skid buffer and streams them as PKT_LEN-beat packets (FIFO_STREAM_DRAIN_PKTCNT_EN adds pkt_count).
// Pop-to-valid 2 cycles, one beat per clock sustained; out_ready=0 freezes the output and stops pops at 2 words in flight.
module fifo_stream_drain #(
   parameter int DATA_WIDTH = 32,
   parameter int PKT_LEN    = 8
) (
   input  logic                clk,
   input  logic                reset,
   fifo_stream_drain_if.master bus
);

   localparam logic [15:0] BEAT_LAST = 16'(PKT_LEN - 1);

   logic [1:0]            occ_q, occ_d;
   logic                  rd_pending_q, rd_pending_d;
   logic [DATA_WIDTH-1:0] head_q, head_d;
   logic [DATA_WIDTH-1:0] tail_q, tail_d;
   logic [15:0]           beat_q, beat_d;
   logic                  out_vld;
   logic                  out_lst;
   logic                  enq;
   logic                  deq;
   logic                  pop;
   logic [2:0]            committed;

   assign out_vld   = (occ_q != 2'd0);
   assign out_lst   = out_vld && (beat_q == BEAT_LAST);
   assign deq       = out_vld && bus.out_ready;
   assign enq       = rd_pending_q;
   // Slots still claimed after this cycle's dequeue; a pop is only safe while one is free.
   assign committed = {1'b0, occ_q} + {2'b00, rd_pending_q} - {2'b00, deq};
   assign pop       = !bus.fifo_empty && (committed < 3'd2);

   assign bus.fifo_read_en = pop;
   assign bus.out_data     = head_q;
   assign bus.out_valid    = out_vld;
   assign bus.out_last     = out_lst;

   always_comb begin
      occ_d        = occ_q;
      head_d       = head_q;
      tail_d       = tail_q;
      rd_pending_d = pop;
      case ({enq, deq})
         2'b10: begin
            if (occ_q == 2'd0) begin
               head_d = bus.fifo_dout;
            end else begin
               tail_d = bus.fifo_dout;
            end
            occ_d = occ_q + 2'd1;
         end
         2'b01: begin
            head_d = tail_q;
            occ_d  = occ_q - 2'd1;
         end
         2'b11: begin
            if (occ_q == 2'd1) begin
               head_d = bus.fifo_dout;
            end else begin
               head_d = tail_q;
               tail_d = bus.fifo_dout;
            end
         end
         default: begin
         end
      endcase
   end

   always_comb begin
      beat_d = beat_q;
      if (deq) begin
         beat_d = (beat_q == BEAT_LAST) ? 16'd0 : beat_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         occ_q        <= 2'd0;
         rd_pending_q <= 1'b0;
         head_q       <= '0;
         tail_q       <= '0;
         beat_q       <= 16'd0;
      end else begin
         occ_q        <= occ_d;
         rd_pending_q <= rd_pending_d;
         head_q       <= head_d;
         tail_q       <= tail_d;
         beat_q       <= beat_d;
      end
   end

   // The pop rule makes a capture into a full, stalled buffer impossible.
   assert property (@(posedge clk) disable iff (reset) !(enq && !deq && (occ_q == 2'd2)));

`ifdef FIFO_STREAM_DRAIN_PKTCNT_EN
   logic [15:0] pkt_cnt_q, pkt_cnt_d;

   always_comb begin
      pkt_cnt_d = pkt_cnt_q;
      if (deq && out_lst) begin
         pkt_cnt_d = pkt_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pkt_cnt_q <= 16'd0;
      end else begin
         pkt_cnt_q <= pkt_cnt_d;
      end
   end

   assign bus.pkt_count = pkt_cnt_q;
`endif

endmodule
